// File: rtl/detection_frame_scheduler_pkg.sv
// detection_pkg: shared types and width helpers for the detection frame
// scheduler slice.
//   state_t  - scheduler FSM states
//   PIX_W    - pixel width
//   coord_w  - bits needed for a coordinate in [0, n-1]
//   cnt_w    - bits needed for a count in [0, n]
package detection_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int unsigned coord_w(input int unsigned n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/detection_frame_scheduler_if.sv
// Pixel stream in (source -> scheduler) and detector stream out
// (scheduler -> detector), bundled as one interface.
//   master: environment side (pixel source and detector)
//   slave : scheduler side
interface detection_frame_scheduler_if;
  import detection_pkg::*;

  logic             src_valid;
  logic [PIX_W-1:0] src_data;
  logic             src_ready;
  logic [PIX_W-1:0] det_pixel;
  logic             det_valid;
  logic             det_object;

  modport master (
    output src_valid, src_data, det_object,
    input  src_ready, det_pixel, det_valid
  );

  modport slave (
    input  src_valid, src_data, det_object,
    output src_ready, det_pixel, det_valid
  );

endinterface

// File: rtl/detection_frame_scheduler_align_pipe.sv
// det_align_pipe: DEPTH-deep shift register of {valid, x, y} that tracks
// each detector input pixel's coordinates until its result comes back.
//   i_clk, i_rst_n     - clock, async active-low reset
//   i_clear            - synchronous flush (all stages invalid)
//   i_valid, i_x, i_y  - stage 0 input, shifted in every cycle
//   o_valid, o_x, o_y  - last stage output
module det_align_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XW    = 6,
  parameter int unsigned YW    = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  output logic          o_valid,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
);

  logic [DEPTH-1:0] r_valid;
  logic [XW-1:0]    r_x [DEPTH];
  logic [YW-1:0]    r_y [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else if (i_clear) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_x[0]     <= i_x;
      r_y[0]     <= i_y;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_x[i]     <= r_x[i-1];
        r_y[i]     <= r_y[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_x     = r_x[DEPTH-1];
  assign o_y     = r_y[DEPTH-1];

endmodule

// File: rtl/detection_frame_scheduler.sv
// detection_frame_scheduler: scans one IMG_W x IMG_H frame from a pixel
// source into the object detector and summarises its per-pixel results.
//   clk, rst         - clock, async active-low reset
//   bus (slave)      - src_valid/src_data/src_ready pixel stream in,
//                      det_pixel/det_valid out, det_object back
//   start, abort     - frame request / terminate
//   busy, frame_done - status (frame_done: one-cycle pulse)
//   hit_count, hit_any, first_hit_x, first_hit_y - frame summary
module detection_frame_scheduler
  import detection_pkg::*;
#(
  parameter int unsigned IMG_W       = 64,
  parameter int unsigned IMG_H       = 48,
  parameter int unsigned DET_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  detection_frame_scheduler_if.slave      bus,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            frame_done,
  output logic [cnt_w(IMG_W*IMG_H)-1:0]   hit_count,
  output logic                            hit_any,
  output logic [coord_w(IMG_W)-1:0]       first_hit_x,
  output logic [coord_w(IMG_H)-1:0]       first_hit_y
);

  localparam int unsigned XW = coord_w(IMG_W);
  localparam int unsigned YW = coord_w(IMG_H);
  localparam int unsigned CW = cnt_w(IMG_W * IMG_H);
  localparam int unsigned DW = cnt_w(DET_LATENCY);

  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DET_LATENCY);

  state_t           r_state, w_state_next;
  logic [XW-1:0]    r_x, r_det_x, r_first_x, w_pipe_x;
  logic [YW-1:0]    r_y, r_det_y, r_first_y, w_pipe_y;
  logic [CW-1:0]    r_hit_count;
  logic             r_hit_any;
  logic [PIX_W-1:0] r_det_pixel;
  logic             r_det_valid;
  logic [DW-1:0]    r_drain_cnt;
  logic             w_pipe_valid;
  logic             w_src_ready, w_busy, w_frame_done;
  logic             w_abort, w_start, w_take, w_last_pix, w_hit;

  assign w_abort    = abort & (r_state != IDLE);
  assign w_start    = start & ~abort & (r_state == IDLE);
  // abort outranks a pixel handshake in the same cycle
  assign w_take     = bus.src_valid & w_src_ready & ~w_abort;
  assign w_last_pix = (r_x == X_LAST) & (r_y == Y_LAST);
  assign w_hit      = w_pipe_valid & bus.det_object & ~w_abort;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_start) w_state_next = SCAN;
        SCAN:    if (w_take && w_last_pix) w_state_next = DRAIN;
        DRAIN:   if (r_drain_cnt == DRAIN_LAST) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM: Moore outputs
  always_comb begin
    w_src_ready  = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE:    w_busy       = 1'b0;
      SCAN:    w_src_ready  = 1'b1;
      DONE:    w_frame_done = 1'b1;
      default: ;
    endcase
  end

  // DRAIN lasts DET_LATENCY+1 cycles: counter runs 0..DET_LATENCY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_drain_cnt <= '0;
    else if (r_state != DRAIN)         r_drain_cnt <= '0;
    else if (r_drain_cnt != DRAIN_LAST) r_drain_cnt <= r_drain_cnt + DW'(1);
  end

  // Scan position, detector drive and frame results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_det_x     <= '0;
      r_det_y     <= '0;
      r_det_pixel <= '0;
      r_det_valid <= 1'b0;
      r_hit_count <= '0;
      r_hit_any   <= 1'b0;
      r_first_x   <= '0;
      r_first_y   <= '0;
    end else begin
      r_det_valid <= w_take;
      if (w_take) begin
        r_det_pixel <= bus.src_data;
        r_det_x     <= r_x;
        r_det_y     <= r_y;
      end
      if (w_start) begin
        r_x         <= '0;
        r_y         <= '0;
        r_hit_count <= '0;
        r_hit_any   <= 1'b0;
        r_first_x   <= '0;
        r_first_y   <= '0;
      end else begin
        if (w_take) begin
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= w_last_pix ? '0 : r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        if (w_hit) begin
          r_hit_count <= r_hit_count + CW'(1);
          if (!r_hit_any) begin
            r_hit_any <= 1'b1;
            r_first_x <= w_pipe_x;
            r_first_y <= w_pipe_y;
          end
        end
      end
    end
  end

  // Pipe is fed from the registered detector inputs so its output lines up
  // with det_object DET_LATENCY cycles after det_valid.
  det_align_pipe #(
    .DEPTH (DET_LATENCY),
    .XW    (XW),
    .YW    (YW)
  ) u_align (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clear (w_start | w_abort),
    .i_valid (r_det_valid),
    .i_x     (r_det_x),
    .i_y     (r_det_y),
    .o_valid (w_pipe_valid),
    .o_x     (w_pipe_x),
    .o_y     (w_pipe_y)
  );

  assign bus.src_ready = w_src_ready;
  assign bus.det_pixel = r_det_pixel;
  assign bus.det_valid = r_det_valid;
  assign busy          = w_busy;
  assign frame_done    = w_frame_done;
  assign hit_count     = r_hit_count;
  assign hit_any       = r_hit_any;
  assign first_hit_x   = r_first_x;
  assign first_hit_y   = r_first_y;

endmodule

// File: tb/tb_detection_frame_scheduler.sv
// Bench for detection_frame_scheduler (IMG_W=4, IMG_H=2, DET_LATENCY=2)
// with a detector model flagging pixels >= 8'h80.
module tb_detection_frame_scheduler;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int LAT   = 2;
  localparam int N     = IMG_W * IMG_H;

  typedef struct {
    int cnt;
    bit any;
    int fx;
    int fy;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, frame_done, hit_any;
  logic [3:0] hit_count;
  logic [1:0] first_hit_x;
  logic       first_hit_y;

  detection_frame_scheduler_if bus ();

  detection_frame_scheduler #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .DET_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .frame_done  (frame_done),
    .hit_count   (hit_count),
    .hit_any     (hit_any),
    .first_hit_x (first_hit_x),
    .first_hit_y (first_hit_y)
  );

  always #5 clk = ~clk;

  // Detector model: result for det_valid in cycle c appears LAT cycles later
  logic [LAT-1:0] det_sr = '0;
  always @(posedge clk) det_sr <= {det_sr[LAT-2:0], bus.det_valid & (bus.det_pixel >= 8'h80)};
  assign bus.det_object = det_sr[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         s_cyc   = 0;
  int         st      = 0;
  logic [7:0] pix [N];
  logic [7:0] exp_pix [$];
  frame_t     fq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Detector stream scoreboard
  always @(negedge clk) begin
    if (rst && bus.det_valid) begin
      if (exp_pix.size() == 0) chk("det_extra", bus.det_valid, 0);
      else                     chk("det_pixel", bus.det_pixel, exp_pix.pop_front());
    end
  end

  task automatic do_start(input bit track);
    frame_t f;
    f = '{0, 0, 0, 0};
    if (track) begin
      for (int i = 0; i < N; i++) begin
        if (pix[i] >= 8'h80) begin
          if (!f.any) begin
            f.fx = i % IMG_W;
            f.fy = i / IMG_W;
          end
          f.any = 1'b1;
          f.cnt++;
        end
      end
      fq.push_back(f);
    end
    start = 1'b1;
    @(negedge clk);
    s_cyc = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive_frame(input int n, input bit stall, input int start_at, output int stalls);
    bit rdy;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0) begin
        bus.src_valid = 1'b0;
        @(negedge clk);
        chk("bubble_hi", bus.det_valid, 1);
        @(posedge clk);
        #1 stalls++;
      end
      bus.src_valid = 1'b1;
      bus.src_data  = pix[i];
      start         = (i == start_at);
      @(negedge clk);
      rdy = bus.src_ready;
      if (stall && i > 0) chk("bubble_lo", bus.det_valid, 0);
      @(posedge clk);
      if (rdy) exp_pix.push_back(pix[i]);
      #1;
      if (!rdy) begin
        chk("src_ready", rdy, 1);
        break;
      end
    end
    bus.src_valid = 1'b0;
    start         = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    bit     seen;
    frame_t f;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      chk("done_timeout", seen, 1);
    end else begin
      chk("done_lat", cyc - s_cyc, exp_lat);
      if (fq.size() == 0) begin
        chk("frame_sb", fq.size(), 1);
      end else begin
        f = fq.pop_front();
        chk("hit_count", hit_count, f.cnt);
        chk("hit_any", hit_any, f.any);
        chk("first_x", first_hit_x, f.fx);
        chk("first_y", first_hit_y, f.fy);
      end
      @(negedge clk);
      chk("done_pulse", frame_done, 0);
      chk("idle_after", busy, 0);
    end
    chk("pix_sb_empty", exp_pix.size(), 0);
  endtask

  task automatic set_pix(input logic [8*N-1:0] v);
    for (int i = 0; i < N; i++) pix[i] = v[8*(N-1-i) +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.src_valid = 1'b1;
    bus.src_data  = 8'hAA;
    start         = 1'b1;
    // Reset held: requests must not leak through
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.src_ready, 0);
    chk("rst_dvalid", bus.det_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_pixel", bus.det_pixel, 0);
    chk("rst_results", {hit_count, hit_any, first_hit_x, first_hit_y}, 0);
    start         = 1'b0;
    bus.src_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, no stalls
    set_pix({8'h10, 8'h20, 8'h80, 8'h90, 8'h40, 8'hFF, 8'h00, 8'h00});
    do_start(1);
    chk("ready_rise", bus.src_ready, 1);
    drive_frame(N, 0, -1, st);
    wait_done(N + LAT + 1);

    // Same data with a bubble before every pixel after the first
    do_start(1);
    drive_frame(N, 1, -1, st);
    wait_done(N + LAT + 1 + st);

    // abort together with start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle", busy, 0);

    // Abort after 5 accepts, once their results have landed
    do_start(0);
    drive_frame(5, 0, -1, st);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.src_ready, 0);
    chk("abort_count", hit_count, 2);
    chk("abort_any", hit_any, 1);
    chk("abort_fx", first_hit_x, 2);
    chk("abort_fy", first_hit_y, 0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_sb_empty", exp_pix.size(), 0);

    // No hits; the start also clears the aborted frame's results
    set_pix('0);
    @(posedge clk);
    #1 do_start(1);
    chk("clr_count", hit_count, 0);
    chk("clr_any", hit_any, 0);
    chk("clr_fx", first_hit_x, 0);
    drive_frame(N, 0, -1, st);
    wait_done(N + LAT + 1);

    // start pulsed mid-SCAN is ignored; first hit on line 1
    set_pix({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h90});
    @(posedge clk);
    #1 do_start(1);
    drive_frame(N, 0, 3, st);
    wait_done(N + LAT + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/detection_frame_scheduler.md
# detection_frame_scheduler

Sequences one image frame at a time from a pixel source into `object_detection_system` and collects its per-pixel `object_detected` results into a frame-level summary. Sits between the pixel source (valid/ready stream) and the detector datapath. Owns frame start/stop, the row/column position, alignment of detector latency to pixel coordinates, and the hit count and first-hit location reported to the host.

## Interface
Parameters:
- `IMG_W`, 64: pixels per line (≥2).
- `IMG_H`, 48: lines per frame (≥2).
- `DET_LATENCY`, 2: cycles from `det_valid` high to the matching `det_object` (≥1).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-low. Asserting it forces all state and outputs to reset values immediately.
- `start` in 1: one-cycle request to scan a frame. Honoured only in IDLE.
- `abort` in 1: terminate the current frame. Has priority over everything except `rst`.
- `src_valid` in 1: source pixel valid.
- `src_data` in 8: source pixel value.
- `src_ready` out 1: scheduler accepts a pixel this cycle.
- `det_pixel` out 8: pixel to the detector (`pixel_data`).
- `det_valid` out 1: `det_pixel` is a real pixel this cycle.
- `det_object` in 1: detector `object_detected`.
- `busy` out 1: state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse on frame completion.
- `hit_count` out clog2(IMG_W*IMG_H+1): number of detected pixels in the last/current frame.
- `hit_any` out 1: at least one hit this frame.
- `first_hit_x` out clog2(IMG_W): column of the first hit.
- `first_hit_y` out clog2(IMG_H): line of the first hit.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE → SCAN on `start`. On the same edge, clear `x`, `y`, `hit_count`, `hit_any`, `first_hit_x`, `first_hit_y`, and the alignment pipe.
- SCAN:
  - `src_ready`=1.
  - Accept = `src_valid & src_ready`. On accept, register `det_pixel<=src_data` and `det_valid<=1`; otherwise `det_valid<=0` and `det_pixel` holds.
  - On accept, `x` increments. When `x` is `IMG_W-1`, it wraps to 0 and `y` increments.
  - Accepting pixel (`IMG_W-1`, `IMG_H-1`) moves to DRAIN.
- Alignment pipe:
  - DET_LATENCY-stage shift register of {valid, x, y}. It is loaded alongside `det_valid` and shifts every cycle, stalled or not.
  - A hit is `pipe_out.valid & det_object`. `det_object` is ignored when `pipe_out.valid`=0.
- On a hit:
  - `hit_count`+1. It cannot overflow because its width covers IMG_W*IMG_H.
  - If `hit_any`=0, capture `first_hit_x/y` from `pipe_out` and set `hit_any`.
- DRAIN: `src_ready`=0 and `det_valid`=0. Stays DET_LATENCY+1 cycles so the last pixel's result is counted, then goes to DONE.
- DONE: `frame_done`=1 for one cycle, then IDLE. Results hold until the next `start`.
- `start` outside IDLE is ignored.
- `abort` in any non-IDLE state:
  - Next state is IDLE. `src_ready`, `det_valid` and `frame_done` go to 0.
  - The alignment pipe is cleared. Partial results hold.
  - `abort` and `start` together in IDLE: `abort` wins and the state stays IDLE.
- Reset values: state IDLE, `src_ready` 0, `det_valid` 0, `det_pixel` 0, `busy` 0, `frame_done` 0, all result outputs 0.

## Timing
- `src_ready` is a Moore output (state only). It rises the cycle after `start` is sampled.
- For a pixel accepted at edge t:
  - `det_pixel` and `det_valid` are valid in cycle t+1.
  - Its `det_object` is sampled at edge t+1+DET_LATENCY.
  - The result registers update at that edge.
- Stalls (`src_valid`=0) insert `det_valid`=0 bubbles. Counters hold; the pipe still shifts.
- Frame of N=IMG_W*IMG_H pixels with no stalls: `start` edge s, last accept at s+N, `frame_done` high in cycle s+N+DET_LATENCY+2.
- `hit_count` and `first_hit_*` are final when `frame_done` is high.

## Structure
- Shared package `detection_pkg`:
  - state enum {IDLE, SCAN, DRAIN, DONE};
  - `PIX_W`=8;
  - coordinate width functions.
- One natural sub-module, `det_align_pipe`: a parameterised DET_LATENCY-deep shift register of {valid, x, y} with synchronous clear.
- The FSM, counters and result registers stay in the top module.

## Test plan
Use IMG_W=4, IMG_H=2, DET_LATENCY=2, and a detector model that asserts `det_object` for pixel ≥ 8'h80.
- Reset: hold `rst`=0, drive `start`=1 and `src_valid`=1 → `busy`, `src_ready`, `det_valid` and `frame_done` all stay 0; results stay 0.
- Full frame, no stalls: pixels 10,20,80,90,40,FF,00,00 → `frame_done` 12 cycles after `start`, `hit_count`=3, `first_hit_x`=2, `first_hit_y`=0, `hit_any`=1.
- Stalls: same data with `src_valid` low every other cycle → same results. `det_valid` shows bubbles, and `frame_done` is delayed by the stall count.
- No hits: all pixels 8'h00 → `hit_count`=0, `hit_any`=0, `first_hit`=(0,0).
- Abort: `abort` after the 5th accept → IDLE next cycle, no `frame_done` pulse, `hit_count` holds its partial value. A following `start` clears the results.
- Start ignored: pulse `start` mid-SCAN → no restart; the frame completes with the original counts.
